dp_alu_arbiter: RTL

DP_ALU_ARBITER -- requirements
Module: dp_alu_arbiter

---
 rtl/dp_alu_arbiter_if.sv | 35 +++
 rtl/dp_alu_arbiter.sv | 119 +++++++++++
 2 files changed

// File: rtl/dp_alu_arbiter_if.sv
// Request/response bundle for the two-requester ALU arbiter.
// master = requester side, slave = the arbiter.
interface dp_alu_arbiter_if #(parameter int W = 8);
    logic         req0_valid;
    logic [1:0]   req0_op;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;

    logic         req1_valid;
    logic [1:0]   req1_op;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;

    logic         rsp_valid;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic         rsp_carry;
    logic         busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_carry, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_carry, busy
    );
endinterface

// File: rtl/dp_alu_arbiter.sv
// Round-robin arbiter in front of a small shared ALU: accept in IDLE,
// compute in EXEC, strobe the registered result out of RESP.
module dp_alu_arbiter #(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dp_alu_arbiter_if.slave   bus
);
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t       state_q, state_d;
    logic         last_grant_q, last_grant_d;
    logic         id_q, id_d;
    logic [1:0]   op_q, op_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W:0]   res_q, res_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic [W-1:0] rsp_data_q, rsp_data_d;
    logic         rsp_carry_q, rsp_carry_d;

    logic grant0, grant1, ready0, ready1;

    // On contention the requester that did not win last time gets the grant.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        ready0 = (state_q == IDLE) & grant0;
        ready1 = (state_q == IDLE) & grant1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        rsp_valid_d  = 1'b0;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_carry_d  = rsp_carry_q;
        case (state_q)
            IDLE: begin
                if (ready0 | ready1) begin
                    state_d      = EXEC;
                    id_d         = ready1;
                    last_grant_d = ready1;
                    op_d         = ready1 ? bus.req1_op : bus.req0_op;
                    a_d          = ready1 ? bus.req1_a  : bus.req0_a;
                    b_d          = ready1 ? bus.req1_b  : bus.req0_b;
                end
            end
            EXEC: begin
                state_d = RESP;
                // Extending to W+1 bits makes the MSB the carry on ADD and the borrow on SUB.
                case (op_q)
                    OP_ADD:  res_d = {1'b0, a_q} + {1'b0, b_q};
                    OP_SUB:  res_d = {1'b0, a_q} - {1'b0, b_q};
                    OP_AND:  res_d = {1'b0, a_q & b_q};
                    OP_PASS: res_d = {1'b0, a_q};
                    default: res_d = {1'b0, a_q};
                endcase
            end
            RESP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = res_q[W-1:0];
                rsp_carry_d = res_q[W];
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            op_q         <= 2'b00;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_carry_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_carry_q  <= rsp_carry_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.busy       = (state_q != IDLE);
endmodule
